// File: rtl/traffic_phase_scheduler.sv
// Actuated four-approach junction scheduler with pedestrian WALK phase.
// Round-robin green grants bounded by min/max green, followed by yellow and all-red clearance.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       ped_req,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       walk,
  output logic [1:0] phase,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_YELLOW = 3'd2;
  localparam logic [2:0] S_ALLRED = 3'd3;
  localparam logic [2:0] S_WALK   = 3'd4;

  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_LAST  = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] WLK_LAST = CW'(WALK_T - 1);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ped_q, ped_d;
  logic [1:0]    last_q, last_d;

  logic          ped_set, ped_eff, competing, do_arb;
  logic [3:0]    phase_oh;
  logic [2:0]    arb_res;

  // Returns {found, winner}: first set request scanning cyclically from l+1.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic       found;
    logic [1:0] win;
    logic [1:0] c;
    found = 1'b0;
    win   = l;
    for (int k = 1; k <= 4; k++) begin
      c = l + 2'(k);
      if (!found && r[c]) begin
        found = 1'b1;
        win   = c;
      end
    end
    return {found, win};
  endfunction

  assign phase_oh  = 4'b0001 << last_q;
  assign ped_set   = ped_req && (state_q != S_WALK);
  assign ped_eff   = ped_q | ped_set;
  assign competing = (|(req & ~phase_oh)) | ped_eff;
  assign arb_res   = rr_pick(req, last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ped_d   = ped_eff;
    do_arb  = 1'b0;
    if (tick) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_d  = '0;
          do_arb = 1'b1;
        end
        S_GREEN: begin
          if (cnt_q >= MIN_LAST && !req[last_q]) begin
            state_d = S_YELLOW;
            cnt_d   = '0;
          end else if (cnt_q == MAX_LAST) begin
            // Without competing demand the green rests with cnt pinned at its cap.
            if (competing) begin
              state_d = S_YELLOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q;
            end
          end
        end
        S_YELLOW: begin
          if (cnt_q == YEL_LAST) begin
            state_d = S_ALLRED;
            cnt_d   = '0;
          end
        end
        S_ALLRED: begin
          if (cnt_q == AR_LAST) do_arb = 1'b1;
        end
        S_WALK: begin
          if (cnt_q == WLK_LAST) begin
            state_d = S_ALLRED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      // Pedestrian demand, including a press on this very tick, pre-empts vehicles.
      if (do_arb) begin
        cnt_d = '0;
        if (ped_eff) begin
          state_d = S_WALK;
          ped_d   = 1'b0;
        end else if (arb_res[2]) begin
          state_d = S_GREEN;
          last_d  = arb_res[1:0];
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      last_q  <= last_d;
    end
  end

  logic [3:0][2:0] lamp;

  always_comb begin
    lamp = {4{LAMP_R}};
    walk = 1'b0;
    case (state_q)
      S_GREEN:  lamp[last_q] = LAMP_G;
      S_YELLOW: lamp[last_q] = LAMP_Y;
      S_WALK:   walk = 1'b1;
      default:  ;
    endcase
  end

  assign light_M1 = lamp[0];
  assign light_M2 = lamp[1];
  assign light_MT = lamp[2];
  assign light_S  = lamp[3];
  assign phase    = last_q;
  assign busy     = (state_q != S_IDLE);

endmodule
